// File: rtl/core_pkg.sv
// Shared types and constants for the 5-stage MIPS core: ALU opcodes,
// the zero-register index, and the ID/EX control bundle.
package core_pkg;

   typedef enum logic [2:0] {
      AND  = 3'b000,
      OR   = 3'b001,
      ADD  = 3'b010,
      RAND = 3'b100,
      ROR  = 3'b101,
      SUB  = 3'b110,
      SLT  = 3'b111
   } alu_op_t;

   localparam alu_op_t ALU_NOP  = ADD;
   localparam int      REG_ZERO = 0;

   // alucont is plain bits so the undefined opcode 3'b011 still passes through.
   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic [2:0] alucont;
   } ex_ctrl_t;

   localparam ex_ctrl_t CTRL_BUBBLE = '{
      valid:    1'b0,
      regwrite: 1'b0,
      memtoreg: 1'b0,
      memwrite: 1'b0,
      alusrc:   1'b0,
      alucont:  ALU_NOP
   };

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one EX source register: MEM beats WB,
// register 0 is never forwarded, otherwise the register-file value is used.
module fwd_mux
   import core_pkg::*;
#(
   parameter int N  = 32,
   parameter int RW = 5
) (
   input  logic [RW-1:0] idx,
   input  logic [N-1:0]  rf_data,
   input  logic          mem_regwrite,
   input  logic [RW-1:0] mem_writereg,
   input  logic [N-1:0]  mem_data,
   input  logic          wb_regwrite,
   input  logic [RW-1:0] wb_writereg,
   input  logic [N-1:0]  wb_data,
   output logic [N-1:0]  data
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_regwrite && (mem_writereg != RW'(REG_ZERO)) && (mem_writereg == idx);
   assign wb_hit  = wb_regwrite  && (wb_writereg  != RW'(REG_ZERO)) && (wb_writereg  == idx);

   always_comb begin
      // NOTE: every path assigns data, so no latch is inferred.
      data = rf_data;
      if (mem_hit) begin
         data = mem_data;
      end else if (wb_hit) begin
         data = wb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarded ALU operand select and
// load-use hazard detection for the 5-stage MIPS core.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int N  = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [N-1:0]  id_rs_data,
   input  logic [N-1:0]  id_rt_data,
   input  logic [N-1:0]  id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [2:0]    id_alucont,
   input  logic          id_alusrc,
   input  logic          id_regdst,
   input  logic          id_regwrite,
   input  logic          id_memtoreg,
   input  logic          id_memwrite,
   input  logic          mem_regwrite,
   input  logic [RW-1:0] mem_writereg,
   input  logic [N-1:0]  mem_aluout,
   input  logic          wb_regwrite,
   input  logic [RW-1:0] wb_writereg,
   input  logic [N-1:0]  wb_result,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [2:0]    alu_cont,
   output logic          ex_valid,
   output logic [RW-1:0] ex_writereg,
   output logic          ex_regwrite,
   output logic          ex_memtoreg,
   output logic          ex_memwrite,
   output logic [N-1:0]  ex_writedata,
   output logic          load_use_stall
);

   ex_ctrl_t      ctrl_d,     ctrl_q;
   logic [RW-1:0] rs_d,       rs_q;
   logic [RW-1:0] rt_d,       rt_q;
   logic [RW-1:0] writereg_d, writereg_q;
   logic [N-1:0]  rs_data_d,  rs_data_q;
   logic [N-1:0]  rt_data_d,  rt_data_q;
   logic [N-1:0]  imm_d,      imm_q;
   logic [N-1:0]  rs_fwd;
   logic [N-1:0]  rt_fwd;

   // A load in EX whose target the decoding instruction reads cannot be forwarded in time.
   assign load_use_stall = ctrl_q.valid && ctrl_q.memtoreg &&
                           (writereg_q != RW'(REG_ZERO)) && id_valid &&
                           ((writereg_q == id_rs) || (writereg_q == id_rt));

   always_comb begin
      ctrl_d     = ctrl_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      writereg_d = writereg_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      if (flush || (!stall && load_use_stall)) begin
         ctrl_d     = CTRL_BUBBLE;
         rs_d       = '0;
         rt_d       = '0;
         writereg_d = '0;
         rs_data_d  = '0;
         rt_data_d  = '0;
         imm_d      = '0;
      end else if (!stall) begin
         ctrl_d.valid    = id_valid;
         ctrl_d.regwrite = id_regwrite;
         ctrl_d.memtoreg = id_memtoreg;
         ctrl_d.memwrite = id_memwrite;
         ctrl_d.alusrc   = id_alusrc;
         ctrl_d.alucont  = id_alucont;
         rs_d            = id_rs;
         rt_d            = id_rt;
         writereg_d      = id_regdst ? id_rd : id_rt;
         rs_data_d       = id_rs_data;
         rt_data_d       = id_rt_data;
         imm_d           = id_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= CTRL_BUBBLE;
         rs_q       <= '0;
         rt_q       <= '0;
         writereg_q <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values of its peers.
         ctrl_q     <= ctrl_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         writereg_q <= writereg_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
      end
   end

   fwd_mux #(.N(N), .RW(RW)) u_fwd_rs (
      .idx          (rs_q),
      .rf_data      (rs_data_q),
      .mem_regwrite (mem_regwrite),
      .mem_writereg (mem_writereg),
      .mem_data     (mem_aluout),
      .wb_regwrite  (wb_regwrite),
      .wb_writereg  (wb_writereg),
      .wb_data      (wb_result),
      .data         (rs_fwd)
   );

   fwd_mux #(.N(N), .RW(RW)) u_fwd_rt (
      .idx          (rt_q),
      .rf_data      (rt_data_q),
      .mem_regwrite (mem_regwrite),
      .mem_writereg (mem_writereg),
      .mem_data     (mem_aluout),
      .wb_regwrite  (wb_regwrite),
      .wb_writereg  (wb_writereg),
      .wb_data      (wb_result),
      .data         (rt_fwd)
   );

   assign alu_a        = rs_fwd;
   assign alu_b        = ctrl_q.alusrc ? imm_q : rt_fwd;
   assign ex_writedata = rt_fwd;
   assign alu_cont     = ctrl_q.alucont;
   assign ex_valid     = ctrl_q.valid;
   assign ex_writereg  = writereg_q;
   assign ex_regwrite  = ctrl_q.regwrite;
   assign ex_memtoreg  = ctrl_q.memtoreg;
   assign ex_memwrite  = ctrl_q.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, forwarding,
// load-use stall, stall/flush priority and asynchronous reset.
module tb_id_ex_stage;

   localparam int N  = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall, flush, id_valid;
   logic [N-1:0]  id_rs_data, id_rt_data, id_imm;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic [2:0]    id_alucont;
   logic          id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite;
   logic          mem_regwrite, wb_regwrite;
   logic [RW-1:0] mem_writereg, wb_writereg;
   logic [N-1:0]  mem_aluout, wb_result;
   logic [N-1:0]  alu_a, alu_b, ex_writedata;
   logic [2:0]    alu_cont;
   logic          ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, load_use_stall;
   logic [RW-1:0] ex_writereg;

   int total = 0;
   int bad   = 0;

   id_ex_stage #(.N(N), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alucont(id_alucont),
      .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
      .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
      .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
      .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .ex_valid(ex_valid),
      .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
      .ex_memwrite(ex_memwrite), .ex_writedata(ex_writedata),
      .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                            input logic [RW-1:0] rd, input logic [N-1:0] rs_d,
                            input logic [N-1:0] rt_d, input logic [N-1:0] imm,
                            input logic [2:0] op, input logic alusrc, input logic regdst,
                            input logic memtoreg);
      id_valid    = 1'b1;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_rs_data  = rs_d;
      id_rt_data  = rt_d;
      id_imm      = imm;
      id_alucont  = op;
      id_alusrc   = alusrc;
      id_regdst   = regdst;
      id_regwrite = 1'b1;
      id_memtoreg = memtoreg;
      id_memwrite = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_regwrite = 1'b0; mem_writereg = '0; mem_aluout = '0;
      wb_regwrite  = 1'b0; wb_writereg  = '0; wb_result  = '0;
      set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd9, 3'b110, 1'b0, 1'b1, 1'b0);

      // Reset held with live ID inputs
      step(); step();
      check("rst_alu_a", alu_a, 32'h0);
      check("rst_alu_b", alu_b, 32'h0);
      check("rst_alu_cont", 32'(alu_cont), 32'h2);
      check("rst_ex_valid", 32'(ex_valid), 32'h0);
      check("rst_load_use", 32'(load_use_stall), 32'h0);

      // Plain capture, register operand
      rst_n = 1'b1;
      step();
      check("cap_alu_a", alu_a, 32'd5);
      check("cap_alu_b", alu_b, 32'd7);
      check("cap_alu_cont", 32'(alu_cont), 32'h6);
      check("cap_ex_valid", 32'(ex_valid), 32'h1);
      check("cap_writereg_rd", 32'(ex_writereg), 32'd3);
      check("cap_regwrite", 32'(ex_regwrite), 32'h1);

      // Immediate operand, destination rt
      set_instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'hFFFF_FFFC, 3'b110, 1'b1, 1'b0, 1'b0);
      step();
      check("imm_alu_b", alu_b, 32'hFFFF_FFFC);
      check("imm_writedata", ex_writedata, 32'd7);
      check("imm_writereg_rt", 32'(ex_writereg), 32'd2);

      // Forwarding priority on rs=3, rt=5 (held by stall)
      set_instr(5'd3, 5'd5, 5'd8, 32'h33, 32'h55, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
      step();
      stall = 1'b1;
      mem_regwrite = 1'b1; mem_writereg = 5'd3; mem_aluout = 32'h11;
      wb_regwrite  = 1'b1; wb_writereg  = 5'd3; wb_result  = 32'h22;
      #1;
      check("fwd_mem_wins", alu_a, 32'h11);
      check("fwd_rt_nomatch", alu_b, 32'h55);
      mem_regwrite = 1'b0;
      #1;
      check("fwd_wb", alu_a, 32'h22);
      mem_regwrite = 1'b1; mem_writereg = 5'd0; wb_writereg = 5'd0;
      #1;
      check("fwd_r0_blocked", alu_a, 32'h33);
      mem_writereg = 5'd5;
      #1;
      check("fwd_rt_alu_b", alu_b, 32'h11);
      check("fwd_rt_writedata", ex_writedata, 32'h11);
      mem_regwrite = 1'b0; mem_writereg = '0; wb_regwrite = 1'b0;
      stall = 1'b0;

      // Load-use hazard: lw r4 in EX, dependent instruction in ID
      set_instr(5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 32'h8, 3'b010, 1'b1, 1'b0, 1'b1);
      step();
      check("lw_memtoreg", 32'(ex_memtoreg), 32'h1);
      check("lw_writereg", 32'(ex_writereg), 32'd4);
      set_instr(5'd4, 5'd6, 5'd7, 32'h40, 32'h60, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
      id_valid = 1'b0;
      #1;
      check("lu_idle_no_stall", 32'(load_use_stall), 32'h0);
      id_valid = 1'b1;
      #1;
      check("lu_stall", 32'(load_use_stall), 32'h1);
      step();
      check("lu_bubble_valid", 32'(ex_valid), 32'h0);
      check("lu_bubble_regwrite", 32'(ex_regwrite), 32'h0);
      check("lu_bubble_cont", 32'(alu_cont), 32'h2);
      check("lu_stall_clears", 32'(load_use_stall), 32'h0);
      step();
      check("lu_dep_valid", 32'(ex_valid), 32'h1);
      check("lu_dep_cont", 32'(alu_cont), 32'h0);
      check("lu_dep_writereg", 32'(ex_writereg), 32'd7);
      check("lu_dep_alu_a", alu_a, 32'h40);

      // Stall holds contents for three cycles while ID changes
      set_instr(5'd9, 5'd10, 5'd11, 32'h999, 32'h777, 32'h0, 3'b111, 1'b0, 1'b1, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_alu_a", alu_a, 32'h40);
         check("stall_alu_b", alu_b, 32'h60);
         check("stall_alu_cont", 32'(alu_cont), 32'h0);
      end

      // Flush beats stall
      flush = 1'b1;
      step();
      check("flush_valid", 32'(ex_valid), 32'h0);
      check("flush_regwrite", 32'(ex_regwrite), 32'h0);
      check("flush_cont", 32'(alu_cont), 32'h2);
      check("flush_alu_a", alu_a, 32'h0);

      // Resume, then asynchronous reset between edges
      flush = 1'b0; stall = 1'b0;
      step();
      check("resume_alu_a", alu_a, 32'h999);
      check("resume_cont", 32'(alu_cont), 32'h7);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_alu_a", alu_a, 32'h0);
      check("arst_valid", 32'(ex_valid), 32'h0);
      check("arst_cont", 32'(alu_cont), 32'h2);
      step();
      rst_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
